// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA operand-preparation stages.
package rsa_pkg;

  localparam int unsigned N     = 1024;
  localparam int unsigned LOG_N = 10;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DOUBLE,
    DONE
  } state_t;

  typedef struct packed {
    logic [N-1:0]     r_mod_m;
    logic [N-1:0]     r2_mod_m;
    logic [LOG_N-1:0] e_length;
  } result_t;

endpackage

// File: rtl/rsa_precompute_mod_double.sv
// Combinational (2t) mod m, valid when t < m; one N+1-bit compare/subtract.
module mod_double #(
  parameter int unsigned N = 1024
) (
  input  logic [N-1:0] t,
  input  logic [N-1:0] m,
  output logic [N-1:0] y
);

  logic [N:0] u;
  logic [N:0] diff;

  always_comb begin
    u    = {t, 1'b0};
    diff = u - {1'b0, m};
    y    = (u >= {1'b0, m}) ? diff[N-1:0] : u[N-1:0];
  end

endmodule

// File: rtl/rsa_precompute.sv
// Derives R mod M, R^2 mod M (R = 2^N) by repeated modular doubling, plus
// the exponent bit length from an MSB scan running alongside the doubling.
module rsa_precompute
  import rsa_pkg::*;
#(
  parameter int unsigned N     = rsa_pkg::N,
  parameter int unsigned LOG_N = rsa_pkg::LOG_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     in_m,
  input  logic [N-1:0]     in_e,
  output logic             busy,
  output logic [N-1:0]     r_mod_m,
  output logic [N-1:0]     r2_mod_m,
  output logic [LOG_N-1:0] e_length,
  output logic             err,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(2 * N);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * N - 1);

  state_t           state, state_next;
  logic [N-1:0]     m_reg;
  logic [N-1:0]     e_reg;
  logic [N-1:0]     t;
  logic [N-1:0]     t_next;
  logic [CNT_W-1:0] cnt;
  logic [LOG_N-1:0] p;
  logic             found;
  logic             invalid;

  mod_double #(.N(N)) u_mod_double (
    .t (t),
    .m (m_reg),
    .y (t_next)
  );

  always_comb begin
    invalid = ~m_reg[0] || (m_reg <= N'(1)) || (e_reg == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CHECK;
      CHECK:   state_next = invalid ? DONE : DOUBLE;
      DOUBLE:  if (cnt == CNT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg    <= '0;
      e_reg    <= '0;
      t        <= '0;
      cnt      <= '0;
      p        <= '0;
      found    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      r_mod_m  <= '0;
      r2_mod_m <= '0;
      e_length <= '0;
    end else begin
      // done is registered from DONE so it lands 2N+2 edges after start
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= in_m;
            e_reg <= in_e;
            t     <= N'(1);
            cnt   <= '0;
            p     <= LOG_N'(N - 1);
            found <= 1'b0;
            busy  <= 1'b1;
          end
        end
        CHECK: begin
          if (invalid) begin
            err      <= 1'b1;
            r_mod_m  <= '0;
            r2_mod_m <= '0;
            e_length <= '0;
          end else begin
            err <= 1'b0;
          end
        end
        DOUBLE: begin
          t   <= t_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_MID)  r_mod_m  <= t_next;
          if (cnt == CNT_LAST) r2_mod_m <= t_next;
          // e != 0 guarantees the scan resolves within the first N cycles
          if ((cnt < CNT_HALF) && !found) begin
            if (e_reg[p]) begin
              e_length <= p + 1'b1;
              found    <= 1'b1;
            end else begin
              p <= p - 1'b1;
            end
          end
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_precompute.sv
// Directed bench: an N=8 instance for fast functional cases, an N=1024
// instance for full-width latency and boundary operands.
module tb_rsa_precompute;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          start8 = 1'b0;
  logic [7:0]    m8 = '0, e8 = '0;
  logic          busy8, err8, done8;
  logic [7:0]    r8, rr8;
  logic [2:0]    len8;

  logic          start1k = 1'b0;
  logic [1023:0] m1k = '0, e1k = '0;
  logic          busy1k, err1k, done1k;
  logic [1023:0] r1k, rr1k;
  logic [9:0]    len1k;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rsa_precompute #(.N(8), .LOG_N(3)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .in_m(m8), .in_e(e8),
    .busy(busy8), .r_mod_m(r8), .r2_mod_m(rr8), .e_length(len8),
    .err(err8), .done(done8)
  );

  rsa_precompute #(.N(1024), .LOG_N(10)) u_dut1k (
    .clk(clk), .rst(rst), .start(start1k), .in_m(m1k), .in_e(e1k),
    .busy(busy1k), .r_mod_m(r1k), .r2_mod_m(rr1k), .e_length(len1k),
    .err(err1k), .done(done1k)
  );

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start, let one edge sample them, then drop start.
  task automatic launch(input bit big, input logic [1023:0] m, input logic [1023:0] e);
    if (big) begin
      m1k = m; e1k = e; start1k = 1'b1;
    end else begin
      m8 = m[7:0]; e8 = e[7:0]; start8 = 1'b1;
    end
    tick();
    start8  = 1'b0;
    start1k = 1'b0;
  endtask

  task automatic wait_done(input bit big, input int limit, output int k);
    k = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (big ? done1k : done8) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int k;
    int ndone;
    int dedge;
    logic [1023:0] all_ones;
    all_ones = '1;

    // Reset values (asynchronous, before any clock edge)
    #3;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_err8",  err8,  0);
    chk("rst_r8",    r8,    0);
    chk("rst_rr8",   rr8,   0);
    chk("rst_len8",  len8,  0);
    chk("rst_r1k",   r1k,   0);
    chk("rst_len1k", len1k, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // N=8, M=13, e=5
    launch(0, 13, 5);
    chk("m13_busy", busy8, 1);
    wait_done(0, 40, k);
    chk("m13_lat",  k,    18);
    chk("m13_err",  err8, 0);
    chk("m13_r",    r8,   9);
    chk("m13_rr",   rr8,  3);
    chk("m13_len",  len8, 3);
    chk("m13_busy_done", busy8, 0);
    tick();
    chk("m13_done_pulse", done8, 0);

    // N=8, M=11, e=0x80: MSB at N-1 wraps the length to 0
    launch(0, 11, 8'h80);
    wait_done(0, 40, k);
    chk("m11_lat", k,    18);
    chk("m11_r",   r8,   3);
    chk("m11_rr",  rr8,  9);
    chk("m11_len", len8, 0);
    tick();

    // N=1024, M=3, e=1
    launch(1, 3, 1);
    wait_done(1, 2100, k);
    chk("m3_lat", k,     2050);
    chk("m3_err", err1k, 0);
    chk("m3_r",   r1k,   1);
    chk("m3_rr",  rr1k,  1);
    chk("m3_len", len1k, 1);
    tick();

    // N=1024, M=2^1024-1, e=all ones
    launch(1, all_ones, all_ones);
    wait_done(1, 2100, k);
    chk("mmax_lat", k,     2050);
    chk("mmax_r",   r1k,   1);
    chk("mmax_rr",  rr1k,  1);
    chk("mmax_len", len1k, 0);
    tick();

    // Invalid operands: even M, M=1, e=0
    launch(1, 12, 5);
    wait_done(1, 10, k);
    chk("even_lat", k,     2);
    chk("even_err", err1k, 1);
    chk("even_r",   r1k,   0);
    chk("even_rr",  rr1k,  0);
    chk("even_len", len1k, 0);
    tick();
    launch(0, 1, 5);
    wait_done(0, 10, k);
    chk("m1_lat", k,    2);
    chk("m1_err", err8, 1);
    chk("m1_r",   r8,   0);
    tick();
    launch(0, 13, 5);
    wait_done(0, 40, k);
    chk("recover_err", err8, 0);
    chk("recover_r",   r8,   9);
    tick();
    launch(0, 13, 0);
    wait_done(0, 10, k);
    chk("e0_lat", k,    2);
    chk("e0_err", err8, 1);
    chk("e0_len", len8, 0);
    tick();

    // Reset mid-run (N=1024, around cycle 500)
    launch(1, 3, 1);
    launch(0, 13, 5);
    repeat (498) tick();
    chk("mid_busy_pre", busy1k, 1);
    rst = 1'b1;
    #1;
    chk("mid_busy1k", busy1k, 0);
    chk("mid_busy8",  busy8,  0);
    chk("mid_err8",   err8,   0);
    chk("mid_r8",     r8,     0);
    chk("mid_len8",   len8,   0);
    chk("mid_r1k",    r1k,    0);
    chk("mid_rr1k",   rr1k,   0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 1600; i++) begin
      tick();
      if (done1k || done8) ndone++;
    end
    chk("mid_no_done", ndone, 0);
    launch(0, 13, 5);
    wait_done(0, 40, k);
    chk("mid_restart_lat", k,    18);
    chk("mid_restart_r",   r8,   9);
    chk("mid_restart_rr",  rr8,  3);
    chk("mid_restart_len", len8, 3);
    tick();

    // Prime with M=11 so the next run's results are distinguishable
    launch(0, 11, 8'h80);
    wait_done(0, 40, k);
    tick();

    // start held high across a run, operands changed while busy
    m8 = 13; e8 = 5; start8 = 1'b1;
    tick();
    ndone = 0; dedge = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 5) begin m8 = 11; e8 = 8'h80; end
      if (done8) begin ndone++; dedge = i; end
      if (i == 18) start8 = 1'b0;
    end
    chk("hold_ndone", ndone, 1);
    chk("hold_edge",  dedge, 18);
    chk("hold_r",     r8,    9);
    chk("hold_rr",    rr8,   3);
    chk("hold_len",   len8,  3);

    // start re-pulsed mid-run with different operands
    launch(0, 11, 8'h80);
    ndone = 0; dedge = 0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 5) begin m8 = 13; e8 = 5; start8 = 1'b1; end
      tick();
      start8 = 1'b0;
      if (done8) begin ndone++; dedge = i; end
    end
    chk("repulse_ndone", ndone, 1);
    chk("repulse_edge",  dedge, 18);
    chk("repulse_r",     r8,    3);
    chk("repulse_rr",    rr8,   9);
    chk("repulse_len",   len8,  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
